// File: rtl/fixed_mul_arbiter.sv
// Round-robin front end that shares one pipelined Q4.28 multiplier among NREQ requesters.
// A tag FIFO records the owner of every in-flight product, so responses are routed without knowing the multiplier latency.
module fixed_mul_arbiter #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 28,
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  output logic                  mul_valid_in,
  input  logic [WIDTH-1:0]      mul_result,
  input  logic                  mul_valid_out,
  output logic                  busy,
  output logic                  err_orphan
);
  localparam int RRW = $clog2(NREQ);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fixed_mul_arbiter: NREQ must be in 2..8");
  end
  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fixed_mul_arbiter: TAG_DEPTH must be a power of 2 and at least 2");
  end
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("fixed_mul_arbiter: FRAC must lie inside WIDTH");
  end

  logic [RRW-1:0]   rr;
  logic [RRW-1:0]   rr_next;
  logic [RRW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant;
  logic             issue;
  logic             pop;
  logic             orphan;
  logic             fifo_full;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [RRW-1:0]   tag_mem [TAG_DEPTH];
  logic [RRW-1:0]   head_tag;
  logic [NREQ-1:0]  head_onehot;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Full is judged on the registered count alone, so a pop never frees a slot in the same cycle.
  assign fifo_full = (count == CW'(TAG_DEPTH));

  // Scanning from the far end lets the candidate nearest rr overwrite the others.
  always_comb begin : grant_search
    int             idx;
    logic [RRW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    if (!fifo_full && !rst) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(rr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        cand = RRW'(idx);
        if (req_valid[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign req_ready = grant;
  assign issue     = |grant;
  assign sel_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign rr_next   = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

  assign pop      = mul_valid_out & (count != '0);
  assign orphan   = mul_valid_out & (count == '0);
  assign head_tag = tag_mem[rd_ptr];

  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      head_onehot[i] = (head_tag == RRW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_valid_in <= 1'b0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      err_orphan   <= 1'b0;
    end else begin
      mul_valid_in <= issue;
      if (issue) begin
        rr     <= rr_next;
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        wr_ptr <= wr_ptr + 1'b1;
      end
      rsp_valid <= pop ? head_onehot : '0;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        rsp_result <= mul_result;
      end
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (orphan) err_orphan <= 1'b1;
    end
  end

  assign busy = (count != '0) | mul_valid_in;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Bench for fixed_mul_arbiter: a latency-3 Q4.28 multiplier stub, a queue-based reference model
// checked every cycle, and hand-computed expectations for the directed scenarios.
module tb_fixed_mul_arbiter;
  localparam int WIDTH     = 32;
  localparam int FRAC      = 28;
  localparam int NREQ      = 4;
  localparam int TAG_DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_valid_in;
  logic [WIDTH-1:0]      mul_result;
  logic                  mul_valid_out;
  logic                  busy;
  logic                  err_orphan;

  always #5 clk = ~clk;

  fixed_mul_arbiter #(.WIDTH(WIDTH), .FRAC(FRAC), .NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid_in(mul_valid_in),
    .mul_result(mul_result), .mul_valid_out(mul_valid_out),
    .busy(busy), .err_orphan(err_orphan)
  );

  // Multiplier stub: 3-cycle pipeline, not reset, so in-flight work survives a block reset.
  function automatic logic [WIDTH-1:0] qmul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [63:0] p;
    p = 64'($signed(a)) * 64'($signed(b));
    return p[FRAC +: WIDTH];
  endfunction

  logic [2:0]       pv = '0;
  logic [WIDTH-1:0] pr [3] = '{default: '0};
  logic             stub_en = 1'b1;
  logic             force_mvo = 1'b0;
  logic [WIDTH-1:0] force_res = '0;

  always @(posedge clk) begin
    pv    <= {pv[1:0], mul_valid_in};
    pr[0] <= qmul(mul_a, mul_b);
    pr[1] <= pr[0];
    pr[2] <= pr[1];
  end

  assign mul_valid_out = stub_en ? pv[2] : force_mvo;
  assign mul_result    = stub_en ? pr[2] : force_res;

  // Reference model state
  int               m_rr;
  int               m_tags[$];
  logic [WIDTH-1:0] m_a, m_b, m_res;
  logic             m_mvi, m_err;
  logic [NREQ-1:0]  m_rsp;

  logic [WIDTH-1:0] opa [NREQ];
  logic [WIDTH-1:0] opb [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int               grant_log[$];
  int               hs_cyc_log[$];
  int               rsp_owner_log[$];
  logic [WIDTH-1:0] rsp_res_log[$];
  int               rsp_cyc_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_rr  = 0;
    m_tags.delete();
    m_a   = '0;
    m_b   = '0;
    m_res = '0;
    m_mvi = 1'b0;
    m_err = 1'b0;
    m_rsp = '0;
  endtask

  function automatic int exp_grant_idx();
    if (m_tags.size() == TAG_DEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    hs_cyc_log.delete();
    rsp_owner_log.delete();
    rsp_res_log.delete();
    rsp_cyc_log.delete();
  endtask

  // One clock: called just after a falling edge with inputs set, returns at the next falling edge.
  task automatic cycle();
    int              g;
    int              h;
    logic [NREQ-1:0] eg;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
    end
    #1;
    g  = exp_grant_idx();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready",    req_ready,    eg);
    check("rsp_valid",    rsp_valid,    m_rsp);
    check("rsp_result",   rsp_result,   m_res);
    check("mul_a",        mul_a,        m_a);
    check("mul_b",        mul_b,        m_b);
    check("mul_valid_in", mul_valid_in, m_mvi);
    check("busy",         busy,         (m_tags.size() != 0) || m_mvi);
    check("err_orphan",   err_orphan,   m_err);
    if (g >= 0) begin
      grant_log.push_back(g);
      hs_cyc_log.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        rsp_owner_log.push_back(i);
        rsp_res_log.push_back(rsp_result);
        rsp_cyc_log.push_back(cyc);
      end
    end
    m_rsp = '0;
    if (mul_valid_out === 1'b1) begin
      if (m_tags.size() > 0) begin
        h        = m_tags.pop_front();
        m_rsp[h] = 1'b1;
        m_res    = mul_result;
      end else begin
        m_err = 1'b1;
      end
    end
    m_mvi = (g >= 0);
    if (g >= 0) begin
      m_tags.push_back(g);
      m_a  = opa[g];
      m_b  = opb[g];
      m_rr = (g + 1) % NREQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    stub_en   = 1'b1;
    force_mvo = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  req_ready,    '0);
    check({tag, "_rsp_valid"},  rsp_valid,    '0);
    check({tag, "_rsp_result"}, rsp_result,   '0);
    check({tag, "_mul_a"},      mul_a,        '0);
    check({tag, "_mul_b"},      mul_b,        '0);
    check({tag, "_mvi"},        mul_valid_in, '0);
    check({tag, "_busy"},       busy,         '0);
    check({tag, "_err"},        err_orphan,   '0);
  endtask

  logic [WIDTH-1:0] fair_a   [NREQ] = '{32'h1000_0000, 32'hE800_0000, 32'h0800_0000, 32'hF000_0000};
  logic [WIDTH-1:0] fair_b   [NREQ] = '{32'h1000_0000, 32'hE800_0000, 32'h4000_0000, 32'h0400_0000};
  logic [WIDTH-1:0] fair_exp [NREQ] = '{32'h1000_0000, 32'h2400_0000, 32'h2000_0000, 32'hFC00_0000};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    #2;
    check_all_zero("reset");
    @(negedge clk);
    do_reset();

    // Single issue from requester 2
    clear_logs();
    opa[2]    = 32'h1000_0000;
    opb[2]    = 32'h2000_0000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    cycle();
    req_valid = '0;
    repeat (10) cycle();
    check("single_nrsp", rsp_owner_log.size(), 1);
    if (rsp_owner_log.size() >= 1 && hs_cyc_log.size() >= 1) begin
      check("single_owner",   rsp_owner_log[0], 2);
      check("single_result",  rsp_res_log[0], 32'h2000_0000);
      check("single_latency", rsp_cyc_log[0] - hs_cyc_log[0], 5);
    end

    // Fairness: all requesters valid for 8 cycles from reset
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = fair_a[i];
      opb[i] = fair_b[i];
    end
    req_valid = 4'hF;
    repeat (8) cycle();
    req_valid = '0;
    repeat (8) cycle();
    check("fair_ngrant", grant_log.size(), 8);
    check("fair_nrsp",   rsp_owner_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size())     check("fair_grant", grant_log[i], i % NREQ);
      if (i < rsp_owner_log.size()) begin
        check("fair_owner",  rsp_owner_log[i], i % NREQ);
        check("fair_result", rsp_res_log[i], fair_exp[i % NREQ]);
      end
    end

    // FIFO full with the multiplier stalled
    do_reset();
    stub_en   = 1'b0;
    force_mvo = 1'b0;
    req_valid = 4'hF;
    repeat (8) cycle();
    #1;
    check("full_ready", req_ready, 4'b0000);
    check("full_busy",  busy, 1'b1);
    cycle();
    force_mvo = 1'b1;
    force_res = 32'h1234_5678;
    #1;
    check("full_pop_ready", req_ready, 4'b0000);
    cycle();
    force_mvo = 1'b0;
    #1;
    check("after_pop_ready",  req_ready,  4'b0001);
    check("after_pop_rsp",    rsp_valid,  4'b0001);
    check("after_pop_result", rsp_result, 32'h1234_5678);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Random traffic through the stub: pushes and pops overlap
    do_reset();
    for (int n = 0; n < 200; n++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      cycle();
    end
    req_valid = '0;
    repeat (6) cycle();

    // Random traffic with a stalling, bursty result strobe (fills, pops at full, orphans)
    do_reset();
    stub_en = 1'b0;
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      force_mvo = ($urandom_range(0, 99) < 40);
      force_res = $urandom;
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
      cycle();
    end

    // Orphan result with an empty FIFO
    do_reset();
    stub_en   = 1'b0;
    force_mvo = 1'b1;
    force_res = 32'h0BAD_0BAD;
    cycle();
    force_mvo = 1'b0;
    #1;
    check("orphan_err", err_orphan, 1'b1);
    check("orphan_rsp", rsp_valid,  4'b0000);
    repeat (5) cycle();
    #1;
    check("orphan_sticky", err_orphan, 1'b1);
    rst = 1'b1;
    #1;
    check("orphan_cleared", err_orphan, 1'b0);
    do_reset();

    // Reset with three tags in flight; requests stay valid across it
    stub_en   = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = fair_a[i];
      opb[i] = fair_b[i];
    end
    req_valid = 4'hF;
    repeat (3) cycle();
    #1;
    check("midrst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) cycle();
    #1;
    check("midrst_orphan", err_orphan, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
